keypad_matrix_scan: RTL and testbench



---
 rtl/keypad_matrix_scan.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_matrix_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner with frame debounce, single-key one-hot output and press strobe.
// Optional auto-repeat of the press strobe is built when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scan #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int REPEAT_FRAMES   = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] onehot,
    output logic [3:0]  key_code,
    output logic        key_press
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

    localparam logic [1:0] COL0 = 2'd0;
    localparam logic [1:0] COL1 = 2'd1;
    localparam logic [1:0] COL2 = 2'd2;
    localparam logic [1:0] COL3 = 2'd3;

    if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_param
        $error("keypad_matrix_scan: parameter out of range");
    end

    function automatic logic is_single(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
    endfunction

    function automatic logic [3:0] onehot_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic [3:0]       r_sync1, r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_state;
    logic [3:0]       r_col;
    logic [15:0]      r_frame, r_prev;
    logic [CNT_W-1:0] r_stable_cnt;
    logic             r_eval, r_upd;
    logic [15:0]      r_onehot;
    logic [3:0]       r_key_code;
    logic             r_key_press;

    logic             w_div_last;
    logic [1:0]       w_state_nxt;
    logic [3:0]       w_col_nxt;
    logic [15:0]      w_frame_nxt;
    logic [15:0]      w_onehot_nxt;
    logic             w_change;
    logic             w_rep_hit;

    assign w_div_last = (r_div == DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        if (w_div_last) begin
            case (r_state)
                COL0:    begin w_state_nxt = COL1; w_col_nxt = 4'b1101; end
                COL1:    begin w_state_nxt = COL2; w_col_nxt = 4'b1011; end
                COL2:    begin w_state_nxt = COL3; w_col_nxt = 4'b0111; end
                COL3:    begin w_state_nxt = COL0; w_col_nxt = 4'b1110; end
                default: begin w_state_nxt = COL0; w_col_nxt = 4'b1110; end
            endcase
        end else begin
            w_state_nxt = r_state;
            w_col_nxt   = r_col;
        end
    end

    // Sample in the last divider cycle so the synchronizer has settled on the new column.
    always_comb begin
        w_frame_nxt = r_frame;
        if (w_div_last) begin
            case (r_state)
                COL0:    {w_frame_nxt[12], w_frame_nxt[8], w_frame_nxt[4], w_frame_nxt[0]} = ~r_sync2;
                COL1:    {w_frame_nxt[13], w_frame_nxt[9], w_frame_nxt[5], w_frame_nxt[1]} = ~r_sync2;
                COL2:    {w_frame_nxt[14], w_frame_nxt[10], w_frame_nxt[6], w_frame_nxt[2]} = ~r_sync2;
                COL3:    {w_frame_nxt[15], w_frame_nxt[11], w_frame_nxt[7], w_frame_nxt[3]} = ~r_sync2;
                default: w_frame_nxt = r_frame;
            endcase
        end else begin
            w_frame_nxt = r_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
            r_div   <= '0;
            r_state <= COL0;
            r_col   <= 4'b1110;
            r_frame <= 16'h0000;
            r_eval  <= 1'b0;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
            r_div   <= w_div_last ? '0 : r_div + DIV_W'(1);
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_frame <= w_frame_nxt;
            r_eval  <= w_div_last && (r_state == COL3);
        end
    end

    // Frame-to-frame comparison runs the cycle after the COL3 sample lands in r_frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev       <= 16'h0000;
            r_stable_cnt <= '0;
            r_upd        <= 1'b0;
        end else begin
            r_upd <= r_eval;
            if (r_eval) begin
                r_prev <= r_frame;
                if (r_frame == r_prev) begin
                    r_stable_cnt <= (r_stable_cnt == CNT_MAX) ? r_stable_cnt
                                                               : r_stable_cnt + CNT_W'(1);
                end else begin
                    r_stable_cnt <= '0;
                end
            end else begin
                r_prev       <= r_prev;
                r_stable_cnt <= r_stable_cnt;
            end
        end
    end

    always_comb begin
        w_onehot_nxt = r_onehot;
        w_change     = 1'b0;
        if (r_upd) begin
            if (r_stable_cnt == CNT_MAX) begin
                w_onehot_nxt = is_single(r_prev) ? r_prev : 16'h0000;
            end else begin
                w_onehot_nxt = r_onehot;
            end
            w_change = (w_onehot_nxt != 16'h0000) && (w_onehot_nxt != r_onehot);
        end else begin
            w_onehot_nxt = r_onehot;
            w_change     = 1'b0;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);

    logic [REP_W-1:0] r_rep_cnt;

    assign w_rep_hit = r_upd && (w_onehot_nxt != 16'h0000) && (w_onehot_nxt == r_onehot)
                       && (r_rep_cnt == REP_LAST);

    // Counts frame ends while the same key stays accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else if (r_upd) begin
            if ((w_onehot_nxt == 16'h0000) || (w_onehot_nxt != r_onehot) || w_rep_hit) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
        end else begin
            r_rep_cnt <= r_rep_cnt;
        end
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_onehot    <= 16'h0000;
            r_key_code  <= 4'd0;
            r_key_press <= 1'b0;
        end else begin
            r_onehot    <= w_onehot_nxt;
            r_key_code  <= (w_onehot_nxt != 16'h0000) ? onehot_index(w_onehot_nxt) : r_key_code;
            r_key_press <= w_change || w_rep_hit;
        end
    end

    assign col       = r_col;
    assign onehot    = r_onehot;
    assign key_code  = r_key_code;
    assign key_press = r_key_press;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan with a behavioural keypad model (SCAN_DIV=4, 3 debounce frames).
module tb_keypad_matrix_scan;

    localparam int FRAME    = 16;
    localparam int MAX_WAIT = 100;
    localparam int MIN_LAT  = 48;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_REP_PULSES = 4;
`else
    localparam int EXP_REP_PULSES = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] onehot;
    logic [3:0]  key_code;
    logic        key_press;

    logic [15:0] keys;
    int          n_checks;
    int          n_errors;
    int          n_press;
    int          n_double;
    logic        prev_press;

    keypad_matrix_scan #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3),
        .REPEAT_FRAMES   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .onehot    (onehot),
        .key_code  (key_code),
        .key_press (key_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its row to the driven-low column.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && keys[4*r+c]) row[r] = 1'b0;
            end
        end
    end

    initial begin
        n_press    = 0;
        n_double   = 0;
        prev_press = 1'b0;
    end

    always @(posedge clk) begin
        if (key_press) n_press++;
        if (key_press && prev_press) n_double++;
        prev_press = key_press;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_onehot(input logic [15:0] exp, output int cyc);
        cyc = 0;
        while ((onehot !== exp) && (cyc < MAX_WAIT)) begin
            @(negedge clk);
            cyc++;
        end
        cycles(1);
    endtask

    int          lat;
    int          base;
    int          bad;
    logic [3:0]  exp_col;

    initial begin
        n_checks = 0;
        n_errors = 0;
        keys     = 16'h0000;
        rst_n    = 1'b0;
        cycles(3);
        check("rst_col", 32'(col), 32'(4'b1110));
        check("rst_onehot", 32'(onehot), 32'h0);
        check("rst_press", 32'(key_press), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            exp_col = 4'b1111;
            exp_col[((i + 1) / 4) % 4] = 1'b0;
            check("col_step", 32'(col), 32'(exp_col));
        end

        // Single press and release of row1/col2.
        base = n_press;
        keys = 16'h0040;
        wait_onehot(16'h0040, lat);
        check("press_onehot", 32'(onehot), 32'h0040);
        check("press_code", 32'(key_code), 32'd6);
        check("press_not_early", 32'(lat >= MIN_LAT), 32'd1);
        cycles(3 * FRAME);
        check("press_pulses", 32'(n_press - base), 32'd1);
        keys = 16'h0000;
        wait_onehot(16'h0000, lat);
        check("release_onehot", 32'(onehot), 32'h0);
        check("release_not_early", 32'(lat >= MIN_LAT), 32'd1);
        check("release_code_held", 32'(key_code), 32'd6);
        cycles(2);
        check("release_no_pulse", 32'(n_press - base), 32'd1);

        // Bouncing key: toggles every frame.
        base = n_press;
        bad  = 0;
        for (int f = 0; f < 12; f++) begin
            keys = (f % 2 == 0) ? 16'h0001 : 16'h0000;
            for (int k = 0; k < FRAME; k++) begin
                cycles(1);
                if (onehot != 16'h0000) bad++;
            end
        end
        keys = 16'h0000;
        check("bounce_onehot", 32'(bad), 32'd0);
        check("bounce_pulses", 32'(n_press - base), 32'd0);
        cycles(5 * FRAME);

        // Two keys together, then release one.
        base = n_press;
        keys = 16'h0021;
        bad  = 0;
        for (int k = 0; k < 6 * FRAME; k++) begin
            cycles(1);
            if (onehot != 16'h0000) bad++;
        end
        check("multi_onehot", 32'(bad), 32'd0);
        check("multi_pulses", 32'(n_press - base), 32'd0);
        keys = 16'h0001;
        wait_onehot(16'h0001, lat);
        check("single_onehot", 32'(onehot), 32'h0001);
        check("single_code", 32'(key_code), 32'd0);
        check("single_not_early", 32'(lat >= MIN_LAT), 32'd1);
        cycles(2);
        check("single_pulses", 32'(n_press - base), 32'd1);

        // Reset while row3/col3 is held.
        keys = 16'h0000;
        wait_onehot(16'h0000, lat);
        check("idle_onehot", 32'(onehot), 32'h0);
        base = n_press;
        keys = 16'h8000;
        wait_onehot(16'h8000, lat);
        check("k15_onehot", 32'(onehot), 32'h8000);
        check("k15_code", 32'(key_code), 32'd15);
        cycles(5);
        check("k15_pulses", 32'(n_press - base), 32'd1);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        check("midrst_onehot", 32'(onehot), 32'h0);
        check("midrst_col", 32'(col), 32'(4'b1110));
        check("midrst_press", 32'(key_press), 32'h0);
        check("midrst_code", 32'(key_code), 32'h0);
        base = n_press;
        wait_onehot(16'h8000, lat);
        check("rearm_onehot", 32'(onehot), 32'h8000);
        check("rearm_code", 32'(key_code), 32'd15);
        check("rearm_not_early", 32'(lat >= MIN_LAT), 32'd1);
        cycles(2);
        check("rearm_pulses", 32'(n_press - base), 32'd1);

        // Long hold of row2/col1.
        keys = 16'h0000;
        wait_onehot(16'h0000, lat);
        base = n_press;
        keys = 16'h0200;
        wait_onehot(16'h0200, lat);
        check("hold_onehot", 32'(onehot), 32'h0200);
        check("hold_code", 32'(key_code), 32'd9);
        cycles(16 * FRAME);
        check("hold_onehot_end", 32'(onehot), 32'h0200);
        check("hold_pulses", 32'(n_press - base), 32'(EXP_REP_PULSES));
        check("pulse_width", 32'(n_double), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
